// File: rtl/deadlock_idx0_monitor_pkg.sv
// Shared types and defaults for the idx0 deadlock monitor.
package deadlock_idx0_monitor_pkg;

  typedef enum logic [1:0] {
    WATCH    = 2'd0,
    STALL    = 2'd1,
    DEADLOCK = 2'd2
  } monitor_state_t;

  localparam int DEFAULT_STALL_LIMIT = 1024;

endpackage

// File: rtl/deadlock_idx0_monitor_stall_timer.sv
// Frozen-stall cycle counter: clear, load-1 or increment, with a terminal flag one
// step before the limit. The count saturates at LIMIT and never wraps.
module stall_timer #(
  parameter int LIMIT = 1024,
  parameter int CNT_W = $clog2(LIMIT) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load_one,
  input  logic incr,
  output logic terminal
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load_one) begin
      count_reg <= CNT_W'(1);
    end else if (incr && (count_reg < CNT_W'(LIMIT))) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign terminal = (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Declares a sticky deadlock when the design stays active and stalled with a frozen
// input snapshot for STALL_LIMIT consecutive cycles.
module deadlock_idx0_monitor
  import deadlock_idx0_monitor_pkg::*;
#(
  parameter int AXIS_NUM    = 2,
  parameter int INST_NUM    = 5,
  parameter int BLOCK_NUM   = 1,
  parameter int STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AXIS_NUM-1:0]  axis_block_sigs,
  input  logic [INST_NUM-1:0]  inst_idle_sigs,
  input  logic [BLOCK_NUM-1:0] inst_block_sigs,
  output logic                 block
);

  localparam int CNT_W = $clog2(STALL_LIMIT) + 1;

  logic [AXIS_NUM-1:0]  axis_snap_reg,  axis_prev_reg;
  logic [INST_NUM-1:0]  idle_snap_reg,  idle_prev_reg;
  logic [BLOCK_NUM-1:0] iblk_snap_reg,  iblk_prev_reg;

  monitor_state_t state_reg;
  logic           block_reg;

  logic active, stall, cond, change;
  logic timer_clear, timer_load, timer_incr, timer_terminal;

  // Current and previous snapshots; all decisions use only these registered copies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      axis_snap_reg <= '0;
      idle_snap_reg <= '0;
      iblk_snap_reg <= '0;
      axis_prev_reg <= '0;
      idle_prev_reg <= '0;
      iblk_prev_reg <= '0;
    end else begin
      axis_snap_reg <= axis_block_sigs;
      idle_snap_reg <= inst_idle_sigs;
      iblk_snap_reg <= inst_block_sigs;
      axis_prev_reg <= axis_snap_reg;
      idle_prev_reg <= idle_snap_reg;
      iblk_prev_reg <= iblk_snap_reg;
    end
  end

  assign active = ~(&idle_snap_reg);
  assign stall  = (|axis_snap_reg) | (|iblk_snap_reg);
  assign cond   = active & stall;
  assign change = (axis_snap_reg != axis_prev_reg) |
                  (idle_snap_reg != idle_prev_reg) |
                  (iblk_snap_reg != iblk_prev_reg);

  always_comb begin
    timer_clear = 1'b0;
    timer_load  = 1'b0;
    timer_incr  = 1'b0;
    unique case (state_reg)
      WATCH: begin
        timer_load  = cond;
        timer_clear = ~cond;
      end
      STALL: begin
        // A changed snapshot while still stalled restarts the run at 1.
        timer_clear = ~cond;
        timer_load  = cond & change;
        timer_incr  = cond & ~change;
      end
      default: ;
    endcase
  end

  stall_timer #(
    .LIMIT (STALL_LIMIT),
    .CNT_W (CNT_W)
  ) u_stall_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .load_one (timer_load),
    .incr     (timer_incr),
    .terminal (timer_terminal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= WATCH;
      block_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        WATCH: begin
          if (cond) state_reg <= STALL;
        end
        STALL: begin
          if (!cond) begin
            state_reg <= WATCH;
          end else if (!change && timer_terminal) begin
            state_reg <= DEADLOCK;
            block_reg <= 1'b1;
          end
        end
        DEADLOCK: begin
          block_reg <= 1'b1;
        end
        default: begin
          state_reg <= WATCH;
          block_reg <= 1'b0;
        end
      endcase
    end
  end

  assign block = block_reg;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Randomised and directed check of the deadlock monitor against a run-length model
// of frozen active stalls, with STALL_LIMIT = 16.
module tb_deadlock_idx0_monitor;

  localparam int AX = 2;
  localparam int IN = 5;
  localparam int BL = 1;
  localparam int L  = 16;
  localparam int SW = AX + IN + BL;

  logic          clock;
  logic          reset;
  logic [AX-1:0] axis_block_sigs;
  logic [IN-1:0] inst_idle_sigs;
  logic [BL-1:0] inst_block_sigs;
  logic          block;

  int n_cmp = 0;
  int n_bad = 0;

  deadlock_idx0_monitor #(
    .AXIS_NUM    (AX),
    .INST_NUM    (IN),
    .BLOCK_NUM   (BL),
    .STALL_LIMIT (L)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: deadlock once L consecutive snapshots are identical and active-and-stalled.
  logic [SW-1:0] m_snap, m_prev;
  int            m_run;
  logic          m_blk;

  function automatic logic cond_of(input logic [SW-1:0] s);
    logic [AX-1:0] a;
    logic [IN-1:0] i;
    logic [BL-1:0] b;
    {a, i, b} = s;
    return (i != {IN{1'b1}}) && ((a != '0) || (b != '0));
  endfunction

  always @(posedge clock or negedge reset) begin : model
    int run_n;
    if (!reset) begin
      m_snap <= '0;
      m_prev <= '0;
      m_run  <= 0;
      m_blk  <= 1'b0;
    end else begin
      if (cond_of(m_snap))
        run_n = (m_run > 0 && m_snap == m_prev) ? m_run + 1 : 1;
      else
        run_n = 0;
      if (run_n > L) run_n = L;
      m_run  <= run_n;
      if (run_n >= L) m_blk <= 1'b1;
      m_prev <= m_snap;
      m_snap <= {axis_block_sigs, inst_idle_sigs, inst_block_sigs};
    end
  end

  always @(negedge clock) begin
    n_cmp++;
    if (block !== m_blk) begin
      n_bad++;
      $display("FAIL cycle_check t=%0t: block=%0b expected %0b", $time, block, m_blk);
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: block=%0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges, then settle 3 time units past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #3;
  endtask

  task automatic drive(input logic [AX-1:0] a, input logic [IN-1:0] i, input logic [BL-1:0] b);
    axis_block_sigs = a;
    inst_idle_sigs  = i;
    inst_block_sigs = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive('0, '0, '0);
    step(3);
    reset = 1'b1;
  endtask

  // Counts edges after the capture edge until block rises (bounded).
  task automatic measure_latency(output int lat);
    lat = 0;
    @(posedge clock);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (block) begin
        lat = k;
        break;
      end
    end
    #2;
  endtask

  initial begin
    int lat;
    logic [AX-1:0] ra;
    logic [IN-1:0] ri;
    logic [BL-1:0] rb;

    reset = 1'b0;
    drive('0, '0, '0);
    #3;
    for (int c = 0; c < 20; c++) begin
      drive(AX'($urandom), IN'($urandom), BL'($urandom));
      step(1);
    end
    chk("reset_hold_random", block, 1'b0);

    drive('0, '0, '0);
    reset = 1'b1;
    step(100);
    chk("idle_zero_inputs", block, 1'b0);

    // Constant active stall
    drive(2'b01, 5'b00000, 1'b0);
    measure_latency(lat);
    chk_int("latency_axis_stall", lat, 16);
    step(200);
    chk("deadlock_sticky", block, 1'b1);

    // Asynchronous reset between edges
    reset = 1'b0;
    #1;
    chk("async_reset_clears", block, 1'b0);
    drive('0, '0, '0);
    step(2);
    reset = 1'b1;
    step(20);
    chk("after_reset_release", block, 1'b0);

    // Toggling stall source keeps restarting the run
    for (int c = 0; c < 50; c++) begin
      drive((c % 2 == 0) ? 2'b01 : 2'b10, 5'b00000, 1'b0);
      step(10);
    end
    chk("toggling_no_deadlock", block, 1'b0);

    do_reset();
    drive(2'b11, 5'b11111, 1'b1);
    step(100);
    chk("all_idle_no_deadlock", block, 1'b0);

    do_reset();
    for (int r = 0; r < 6; r++) begin
      drive(2'b00, 5'b00000, 1'b1);
      step(15);
      drive(2'b00, 5'b00000, 1'b0);
      step(1);
    end
    chk("run15_no_deadlock", block, 1'b0);
    drive(2'b00, 5'b00000, 1'b1);
    measure_latency(lat);
    chk_int("latency_inst_block", lat, 16);
    chk("inst_block_deadlock", block, 1'b1);

    // Random segments of held inputs
    do_reset();
    for (int s = 0; s < 150; s++) begin
      if (m_blk || ($urandom_range(0, 19) == 0)) do_reset();
      ra = AX'($urandom);
      rb = BL'($urandom);
      case ($urandom_range(0, 3))
        0:       ri = {IN{1'b1}};
        1:       ri = '0;
        default: ri = IN'($urandom);
      endcase
      drive(ra, ri, rb);
      step($urandom_range(1, 24));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
